// File: rtl/lidar_tx_scheduler.sv
// Frames 48-bit LiDAR result words behind a two-byte header and streams them byte-wise to the UART serializer.
// Optional build macro LIDAR_TX_CHECKSUM_EN appends an 8-bit modular-sum checksum byte to every packet.
module lidar_tx_scheduler #(
    parameter logic [7:0] HDR0       = 8'h55,
    parameter logic [7:0] HDR1       = 8'hAA,
    parameter int         GAP_CYCLES = 16,
    parameter int         DROP_W     = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              result_valid,
    input  logic [47:0]       result_data,
    output logic [7:0]        tx_byte,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              pkt_done,
    output logic [DROP_W-1:0] drop_count
);

`ifdef LIDAR_TX_CHECKSUM_EN
    localparam logic [3:0] LAST_IDX = 4'd8;
`else
    localparam logic [3:0] LAST_IDX = 4'd7;
`endif
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

    state_t            state_reg;
    logic [47:0]       word_reg;
    logic [47:0]       pend_data_reg;
    logic              pend_valid_reg;
    logic [3:0]        idx_reg;
    logic [GAP_W-1:0]  gap_cnt_reg;
    logic [7:0]        tx_byte_reg;
    logic              tx_valid_reg;
    logic              pkt_done_reg;
    logic [DROP_W-1:0] drop_reg;
`ifdef LIDAR_TX_CHECKSUM_EN
    logic [7:0]        sum_reg;
`endif

    logic [7:0] data_bytes [6];

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_bytes
            assign data_bytes[gi] = word_reg[47-8*gi -: 8];
        end
    endgenerate

    // Byte presented after a transfer of the byte at idx_reg.
    logic [7:0] byte_next;
    always_comb begin
        byte_next = 8'h00;
        case (idx_reg)
            4'd0:    byte_next = HDR1;
            4'd1:    byte_next = data_bytes[0];
            4'd2:    byte_next = data_bytes[1];
            4'd3:    byte_next = data_bytes[2];
            4'd4:    byte_next = data_bytes[3];
            4'd5:    byte_next = data_bytes[4];
            4'd6:    byte_next = data_bytes[5];
`ifdef LIDAR_TX_CHECKSUM_EN
            4'd7:    byte_next = sum_reg + tx_byte_reg;
`endif
            default: byte_next = 8'h00;
        endcase
    end

    // A pending word always launches ahead of a fresh strobe; the strobe then refills pending without a drop.
    logic        launch;
    logic        store;
    logic        drop_inc;
    logic [47:0] launch_word;
    always_comb begin
        launch      = (state_reg == ST_IDLE) && enable && (pend_valid_reg || result_valid);
        launch_word = pend_valid_reg ? pend_data_reg : result_data;
        store       = result_valid && !(launch && !pend_valid_reg);
        drop_inc    = store && pend_valid_reg && !launch;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_IDLE;
            word_reg       <= '0;
            pend_data_reg  <= '0;
            pend_valid_reg <= 1'b0;
            idx_reg        <= '0;
            gap_cnt_reg    <= '0;
            tx_byte_reg    <= '0;
            tx_valid_reg   <= 1'b0;
            pkt_done_reg   <= 1'b0;
            drop_reg       <= '0;
`ifdef LIDAR_TX_CHECKSUM_EN
            sum_reg        <= '0;
`endif
        end else begin
            pkt_done_reg <= 1'b0;

            if (store) begin
                pend_data_reg  <= result_data;
                pend_valid_reg <= 1'b1;
            end else if (launch) begin
                pend_valid_reg <= 1'b0;
            end

            if (drop_inc && (drop_reg != '1))
                drop_reg <= drop_reg + 1'b1;

            case (state_reg)
                ST_IDLE: begin
                    if (launch) begin
                        word_reg     <= launch_word;
                        idx_reg      <= '0;
                        tx_byte_reg  <= HDR0;
                        tx_valid_reg <= 1'b1;
                        state_reg    <= ST_SEND;
`ifdef LIDAR_TX_CHECKSUM_EN
                        sum_reg      <= '0;
`endif
                    end
                end
                ST_SEND: begin
                    if (tx_valid_reg && tx_ready) begin
`ifdef LIDAR_TX_CHECKSUM_EN
                        sum_reg <= sum_reg + tx_byte_reg;
`endif
                        if (idx_reg == LAST_IDX) begin
                            tx_valid_reg <= 1'b0;
                            pkt_done_reg <= 1'b1;
                            gap_cnt_reg  <= '0;
                            state_reg    <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                        end else begin
                            idx_reg     <= idx_reg + 4'd1;
                            tx_byte_reg <= byte_next;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_reg == GAP_W'(GAP_CYCLES - 1))
                        state_reg <= ST_IDLE;
                    else
                        gap_cnt_reg <= gap_cnt_reg + 1'b1;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign tx_byte    = tx_byte_reg;
    assign tx_valid   = tx_valid_reg;
    assign pkt_done   = pkt_done_reg;
    assign drop_count = drop_reg;
    assign busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_lidar_tx_scheduler.sv
// Bench for lidar_tx_scheduler: packet-level model checked every cycle plus directed literal expectations.
module tb_lidar_tx_scheduler;
    localparam int GAP = 16;
`ifdef LIDAR_TX_CHECKSUM_EN
    localparam int PKT_LEN = 9;
`else
    localparam int PKT_LEN = 8;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        result_valid = 1'b0;
    logic [47:0] result_data = '0;
    logic        tx_ready = 1'b0;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        busy;
    logic        pkt_done;
    logic [7:0]  drop_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lidar_tx_scheduler dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .result_valid (result_valid),
        .result_data  (result_data),
        .tx_byte      (tx_byte),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .busy         (busy),
        .pkt_done     (pkt_done),
        .drop_count   (drop_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Packet-level model: a queue of bytes still to deliver, a gap countdown and a one-deep pending slot.
    byte unsigned m_q[$];
    int           m_gap = 0;
    bit           m_pdone = 0;
    bit           m_pend_v = 0;
    logic [47:0]  m_pend_d = '0;
    int           m_drop = 0;

    function automatic void build_packet(input logic [47:0] w);
        byte unsigned s;
        byte unsigned b;
        s = 8'h00;
        m_q.push_back(8'h55);
        m_q.push_back(8'hAA);
        s = s + 8'h55 + 8'hAA;
        for (int i = 5; i >= 0; i--) begin
            b = w[i*8 +: 8];
            m_q.push_back(b);
            s = s + b;
        end
`ifdef LIDAR_TX_CHECKSUM_EN
        m_q.push_back(s);
`endif
    endfunction

    task automatic model_step();
        bit idle;
        bit launch;
        idle   = (m_q.size() == 0) && (m_gap == 0);
        launch = idle && enable && (m_pend_v || result_valid);
        m_pdone = 0;
        if (m_q.size() > 0) begin
            if (tx_ready) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) begin
                    m_pdone = 1;
                    m_gap   = GAP;
                end
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end
        if (launch) begin
            build_packet(m_pend_v ? m_pend_d : result_data);
            if (m_pend_v && result_valid) m_pend_d = result_data;
            else if (m_pend_v)            m_pend_v = 0;
        end else if (result_valid) begin
            if (m_pend_v && m_drop < 255) m_drop++;
            m_pend_v = 1;
            m_pend_d = result_data;
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_q.delete();
            m_gap    = 0;
            m_pdone  = 0;
            m_pend_v = 0;
            m_pend_d = '0;
            m_drop   = 0;
        end else begin
            model_step();
        end
    end

    // Observed transfers and packet completions for the directed literal checks.
    byte unsigned obs[$];
    int           pdone_cnt = 0;
    always @(posedge clk) begin
        if (reset_n) begin
            if (tx_valid && tx_ready) obs.push_back(tx_byte);
            if (pkt_done) pdone_cnt++;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            check("tx_valid", {63'd0, tx_valid}, {63'd0, m_q.size() > 0});
            if (m_q.size() > 0) check("tx_byte", {56'd0, tx_byte}, {56'd0, m_q[0]});
            check("busy", {63'd0, busy}, {63'd0, (m_q.size() > 0) || (m_gap > 0)});
            check("pkt_done", {63'd0, pkt_done}, {63'd0, m_pdone});
            check("drop_count", {56'd0, drop_count}, 64'(m_drop));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe(input logic [47:0] d);
        result_data  = d;
        result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
    endtask

    task automatic wait_idle(input int lim, output int n);
        n = 0;
        while ((busy || tx_valid) && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", {63'd0, busy || tx_valid}, 64'd0);
    endtask

    task automatic wait_done(input int target, input int lim);
        int n;
        n = 0;
        while (pdone_cnt < target && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("pkt_done_timeout", {63'd0, pdone_cnt >= target}, 64'd1);
    endtask

    byte unsigned exp1 [8] = '{8'h55, 8'hAA, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB};
    byte unsigned exp2 [8] = '{8'h55, 8'hAA, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hCA, 8'hFE};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tick(3);
        check("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
        check("rst_tx_byte", {56'd0, tx_byte}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_pkt_done", {63'd0, pkt_done}, 64'd0);
        check("rst_drop", {56'd0, drop_count}, 64'd0);
        reset_n = 1'b1;
        tick(2);

        // Basic packet
        enable = 1'b1;
        tx_ready = 1'b1;
        obs.delete();
        pdone_cnt = 0;
        strobe(48'h0123_4567_89AB);
        check("t1_latency_valid", {63'd0, tx_valid}, 64'd1);
        check("t1_first_byte", {56'd0, tx_byte}, 64'h55);
        wait_idle(100, n);
        check("t1_busy_cycles", 64'(n), 64'(PKT_LEN + GAP));
        check("t1_len", 64'(obs.size()), 64'(PKT_LEN));
        for (int i = 0; i < 8; i++) check($sformatf("t1_byte%0d", i), {56'd0, obs[i]}, {56'd0, exp1[i]});
`ifdef LIDAR_TX_CHECKSUM_EN
        check("t1_checksum", {56'd0, obs[8]}, 64'h03);
`endif
        check("t1_pkt_done_count", 64'(pdone_cnt), 64'd1);

        // Backpressure with ready pattern 1,0,0,1
        obs.delete();
        strobe(48'hDEAD_BEEF_CAFE);
        for (int i = 0; i < 64; i++) begin
            tx_ready = (i % 4 == 0) || (i % 4 == 3);
            tick(1);
        end
        tx_ready = 1'b1;
        wait_idle(100, n);
        check("t2_len", 64'(obs.size()), 64'(PKT_LEN));
        for (int i = 0; i < 8; i++) check($sformatf("t2_byte%0d", i), {56'd0, obs[i]}, {56'd0, exp2[i]});

        // Overrun: A, B, C during a packet, only C survives
        obs.delete();
        pdone_cnt = 0;
        strobe(48'h1111_1111_1111);
        tick(1);
        strobe(48'hA0A1_A2A3_A4A5);
        strobe(48'hB0B1_B2B3_B4B5);
        strobe(48'hC0C1_C2C3_C4C5);
        check("t3_drop", {56'd0, drop_count}, 64'd2);
        wait_done(2, 200);
        wait_idle(100, n);
        check("t3_len", 64'(obs.size()), 64'(2 * PKT_LEN));
        check("t3_c_first", {56'd0, obs[PKT_LEN + 2]}, 64'hC0);
        check("t3_c_last", {56'd0, obs[PKT_LEN + 7]}, 64'hC5);
        strobe(48'hE0E1_E2E3_E4E5);
        check("t3_immediate", {63'd0, tx_valid}, 64'd1);
        wait_idle(100, n);

        // Enable gating
        obs.delete();
        pdone_cnt = 0;
        enable = 1'b0;
        strobe(48'hD0D1_D2D3_D4D5);
        tick(9);
        check("t4_gated_valid", {63'd0, tx_valid}, 64'd0);
        check("t4_gated_busy", {63'd0, busy}, 64'd0);
        enable = 1'b1;
        tick(1);
        check("t4_start_valid", {63'd0, tx_valid}, 64'd1);
        check("t4_start_byte", {56'd0, tx_byte}, 64'h55);
        tick(3);
        enable = 1'b0;
        strobe(48'hF0F1_F2F3_F4F5);
        wait_done(1, 100);
        wait_idle(100, n);
        tick(10);
        check("t4_no_new_valid", {63'd0, tx_valid}, 64'd0);
        check("t4_no_new_busy", {63'd0, busy}, 64'd0);
        enable = 1'b1;
        tick(1);
        check("t4_resume_valid", {63'd0, tx_valid}, 64'd1);
        wait_idle(100, n);
        check("t4_len", 64'(obs.size()), 64'(2 * PKT_LEN));
        check("t4_d_first", {56'd0, obs[2]}, 64'hD0);
        check("t4_f_first", {56'd0, obs[PKT_LEN + 2]}, 64'hF0);
        check("t4_drop_kept", {56'd0, drop_count}, 64'd2);

        // Reset mid-packet
        strobe(48'h0A0B_0C0D_0E0F);
        strobe(48'h9999_9999_9999);
        tick(2);
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_async_valid", {63'd0, tx_valid}, 64'd0);
        check("t5_async_busy", {63'd0, busy}, 64'd0);
        check("t5_async_drop", {56'd0, drop_count}, 64'd0);
        tick(2);
        reset_n = 1'b1;
        tick(3);
        check("t5_pending_cleared", {63'd0, tx_valid}, 64'd0);
        obs.delete();
        strobe(48'h5A5A_00FF_1234);
        check("t5_restart_valid", {63'd0, tx_valid}, 64'd1);
        check("t5_restart_byte", {56'd0, tx_byte}, 64'h55);
        wait_idle(100, n);
        check("t5_len", 64'(obs.size()), 64'(PKT_LEN));
        check("t5_last_data", {56'd0, obs[7]}, 64'h34);

        // Drop counter saturation
        obs.delete();
        enable = 1'b0;
        for (int i = 0; i < 300; i++) begin
            result_data  = 48'(i);
            result_valid = 1'b1;
            tick(1);
        end
        result_valid = 1'b0;
        check("t6_drop_sat", {56'd0, drop_count}, 64'hFF);
        enable = 1'b1;
        tick(1);
        check("t6_launch_valid", {63'd0, tx_valid}, 64'd1);
        wait_idle(100, n);
        check("t6_byte6", {56'd0, obs[6]}, 64'h01);
        check("t6_byte7", {56'd0, obs[7]}, 64'h2B);
        check("t6_drop_hold", {56'd0, drop_count}, 64'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
